hazard_ctrl: RTL and testbench

Central hazard and pipeline-sequencing controller for the 5-stage MIPS core. It drives the enable and clear inputs of the PC, the IF/ID register and the ID/EX register. It detects load-use and branch-operand hazards, sequences stalls for the multi-cycle mult/div unit, and flushes wrong-path fetches after taken branches and jumps. It also keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX hazard inputs in, pipeline enables/clears and counters out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       rs_D;
  logic [4:0]       rt_D;
  logic             MemRead_E;
  logic             RegWrite_E;
  logic [4:0]       WriteReg_E;
  logic             Branch_D;
  logic             BranchTaken_D;
  logic             Jump_D;
  logic             MD_Start_E;
  logic             MD_Use_D;
  logic             Cnt_Clr;
  logic             PC_En;
  logic             IF_En;
  logic             IF_Clr;
  logic             ID_Clr;
  logic             MD_Busy;
  logic [CNT_W-1:0] Stall_Cnt;
  logic [CNT_W-1:0] Flush_Cnt;

  // Pipeline side: drives hazard information, consumes control.
  modport master (
    output rs_D, rt_D, MemRead_E, RegWrite_E, WriteReg_E, Branch_D, BranchTaken_D,
           Jump_D, MD_Start_E, MD_Use_D, Cnt_Clr,
    input  PC_En, IF_En, IF_Clr, ID_Clr, MD_Busy, Stall_Cnt, Flush_Cnt
  );

  // Controller side.
  modport slave (
    input  rs_D, rt_D, MemRead_E, RegWrite_E, WriteReg_E, Branch_D, BranchTaken_D,
           Jump_D, MD_Start_E, MD_Use_D, Cnt_Clr,
    output PC_En, IF_En, IF_Clr, ID_Clr, MD_Busy, Stall_Cnt, Flush_Cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use and
// branch-operand stalls, mult/div occupancy tracking, wrong-path flushes, and
// saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StRun, StMdBusy} state_e;

  localparam logic [5:0] MdReload = 6'(MD_LAT - 1);

  state_e           state_q;
  logic [5:0]       md_cnt_q;
  logic             md_busy_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic src_match;
  logic lu_haz;
  logic br_haz;
  logic md_haz;
  logic stall;
  logic flush;

  // Hazard detection; register 0 is hard-wired and never a real dependency.
  always_comb begin
    src_match = (bus.WriteReg_E != 5'd0) &&
                ((bus.WriteReg_E == bus.rs_D) || (bus.WriteReg_E == bus.rt_D));
    lu_haz    = bus.MemRead_E && src_match;
    br_haz    = bus.Branch_D && bus.RegWrite_E && src_match;
    md_haz    = bus.MD_Use_D && (state_q == StMdBusy);
    stall     = lu_haz || br_haz || md_haz;
    // A redirect seen during a stall is dropped; the branch re-resolves next cycle.
    flush     = (bus.BranchTaken_D || bus.Jump_D) && !stall;
  end

  // Pipeline register controls; reset forces a full bubble and frozen PC.
  always_comb begin
    bus.PC_En  = 1'b1;
    bus.IF_En  = 1'b1;
    bus.IF_Clr = 1'b0;
    bus.ID_Clr = 1'b0;
    if (!rst) begin
      bus.PC_En  = 1'b0;
      bus.IF_En  = 1'b0;
      bus.IF_Clr = 1'b1;
      bus.ID_Clr = 1'b1;
    end else if (stall) begin
      bus.PC_En  = 1'b0;
      bus.IF_En  = 1'b0;
      bus.ID_Clr = 1'b1;
    end else if (flush) begin
      bus.IF_Clr = 1'b1;
    end
  end

  // Mult/div occupancy FSM; starts are only honoured in StRun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRun;
      md_cnt_q  <= 6'd0;
      md_busy_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.MD_Start_E) begin
            state_q   <= StMdBusy;
            md_cnt_q  <= MdReload;
            md_busy_q <= 1'b1;
          end
        end
        StMdBusy: begin
          if (md_cnt_q == 6'd1) begin
            state_q   <= StRun;
            md_cnt_q  <= 6'd0;
            md_busy_q <= 1'b0;
          end else begin
            md_cnt_q  <= md_cnt_q - 6'd1;
          end
        end
        default: begin
          state_q   <= StRun;
          md_cnt_q  <= 6'd0;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.Cnt_Clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.MD_Busy   = md_busy_q;
  assign bus.Stall_Cnt = stall_cnt_q;
  assign bus.Flush_Cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Instance A (MD_LAT=4, CNT_W=4) covers the hazard,
// flush, mult/div and counter cases; instance B (MD_LAT=12) covers reset mid-MD_BUSY.
module tb_hazard_ctrl;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  hazard_ctrl_if #(.CNT_W(4)) bus_a ();
  hazard_ctrl_if #(.CNT_W(8)) bus_b ();

  hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  hazard_ctrl #(.MD_LAT(12), .CNT_W(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed 1ns after a rising edge, well clear of the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    bus_a.rs_D = 5'd0; bus_a.rt_D = 5'd0; bus_a.MemRead_E = 1'b0; bus_a.RegWrite_E = 1'b0;
    bus_a.WriteReg_E = 5'd0; bus_a.Branch_D = 1'b0; bus_a.BranchTaken_D = 1'b0;
    bus_a.Jump_D = 1'b0; bus_a.MD_Start_E = 1'b0; bus_a.MD_Use_D = 1'b0; bus_a.Cnt_Clr = 1'b0;
  endtask

  task automatic clear_b();
    bus_b.rs_D = 5'd0; bus_b.rt_D = 5'd0; bus_b.MemRead_E = 1'b0; bus_b.RegWrite_E = 1'b0;
    bus_b.WriteReg_E = 5'd0; bus_b.Branch_D = 1'b0; bus_b.BranchTaken_D = 1'b0;
    bus_b.Jump_D = 1'b0; bus_b.MD_Start_E = 1'b0; bus_b.MD_Use_D = 1'b0; bus_b.Cnt_Clr = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    clear_a();
    clear_b();

    // Reset state
    #2;
    chk("rst_pc_en", 32'(bus_a.PC_En), 32'd0);
    chk("rst_if_en", 32'(bus_a.IF_En), 32'd0);
    chk("rst_if_clr", 32'(bus_a.IF_Clr), 32'd1);
    chk("rst_id_clr", 32'(bus_a.ID_Clr), 32'd1);
    chk("rst_md_busy", 32'(bus_a.MD_Busy), 32'd0);
    chk("rst_stall_cnt", 32'(bus_a.Stall_Cnt), 32'd0);
    chk("rst_flush_cnt", 32'(bus_a.Flush_Cnt), 32'd0);
    #10;
    rst = 1'b1;
    tick();

    // Idle: free-running pipeline
    #1;
    chk("idle_pc_en", 32'(bus_a.PC_En), 32'd1);
    chk("idle_if_clr", 32'(bus_a.IF_Clr), 32'd0);
    chk("idle_id_clr", 32'(bus_a.ID_Clr), 32'd0);

    // Load-use on rs
    bus_a.MemRead_E = 1'b1; bus_a.WriteReg_E = 5'd8; bus_a.rs_D = 5'd8;
    #1;
    chk("lu_pc_en", 32'(bus_a.PC_En), 32'd0);
    chk("lu_if_en", 32'(bus_a.IF_En), 32'd0);
    chk("lu_id_clr", 32'(bus_a.ID_Clr), 32'd1);
    chk("lu_if_clr", 32'(bus_a.IF_Clr), 32'd0);
    tick();
    chk("lu_stall_cnt", 32'(bus_a.Stall_Cnt), 32'd1);

    // Load to $0 is not a hazard
    bus_a.WriteReg_E = 5'd0; bus_a.rs_D = 5'd0;
    #1;
    chk("lu0_pc_en", 32'(bus_a.PC_En), 32'd1);
    chk("lu0_id_clr", 32'(bus_a.ID_Clr), 32'd0);
    tick();
    chk("lu0_stall_cnt", 32'(bus_a.Stall_Cnt), 32'd1);
    clear_a();

    // Branch operand hazard on rt; taken is suppressed while stalled
    bus_a.Branch_D = 1'b1; bus_a.RegWrite_E = 1'b1; bus_a.WriteReg_E = 5'd5;
    bus_a.rt_D = 5'd5; bus_a.BranchTaken_D = 1'b1;
    #1;
    chk("br_pc_en", 32'(bus_a.PC_En), 32'd0);
    chk("br_id_clr", 32'(bus_a.ID_Clr), 32'd1);
    chk("br_if_clr", 32'(bus_a.IF_Clr), 32'd0);
    tick();
    chk("br_flush_cnt", 32'(bus_a.Flush_Cnt), 32'd0);
    chk("br_stall_cnt", 32'(bus_a.Stall_Cnt), 32'd2);
    bus_a.RegWrite_E = 1'b0;
    #1;
    chk("brt_if_clr", 32'(bus_a.IF_Clr), 32'd1);
    chk("brt_pc_en", 32'(bus_a.PC_En), 32'd1);
    chk("brt_if_en", 32'(bus_a.IF_En), 32'd1);
    chk("brt_id_clr", 32'(bus_a.ID_Clr), 32'd0);
    tick();
    chk("brt_flush_cnt", 32'(bus_a.Flush_Cnt), 32'd1);
    clear_a();

    // Jump flushes for exactly its cycle
    bus_a.Jump_D = 1'b1;
    #1;
    chk("j_if_clr", 32'(bus_a.IF_Clr), 32'd1);
    chk("j_if_en", 32'(bus_a.IF_En), 32'd1);
    chk("j_pc_en", 32'(bus_a.PC_En), 32'd1);
    chk("j_id_clr", 32'(bus_a.ID_Clr), 32'd0);
    tick();
    bus_a.Jump_D = 1'b0;
    #1;
    chk("j_after_if_clr", 32'(bus_a.IF_Clr), 32'd0);
    chk("j_flush_cnt", 32'(bus_a.Flush_Cnt), 32'd2);

    // Mult/div with MD_LAT=4: start at t, busy t+1..t+3; restarts during busy ignored
    bus_a.MD_Start_E = 1'b1;
    #1;
    chk("md_t_busy", 32'(bus_a.MD_Busy), 32'd0);
    tick();
    bus_a.MD_Start_E = 1'b0;
    bus_a.MD_Use_D = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus_a.MD_Start_E = (k >= 2);
      #1;
      chk($sformatf("md_busy_t%0d", k), 32'(bus_a.MD_Busy), 32'd1);
      chk($sformatf("md_stall_t%0d", k), 32'(bus_a.PC_En), 32'd0);
      tick();
    end
    bus_a.MD_Start_E = 1'b0;
    #1;
    chk("md_t4_busy", 32'(bus_a.MD_Busy), 32'd0);
    chk("md_t4_pc_en", 32'(bus_a.PC_En), 32'd1);
    chk("md_stall_cnt", 32'(bus_a.Stall_Cnt), 32'd5);
    bus_a.MD_Use_D = 1'b0;
    tick();
    chk("md_t5_busy", 32'(bus_a.MD_Busy), 32'd0);

    // Stall counter saturates at 15 with CNT_W=4
    bus_a.MemRead_E = 1'b1; bus_a.WriteReg_E = 5'd8; bus_a.rs_D = 5'd8;
    for (int k = 0; k < 20; k++) tick();
    chk("sat_stall_cnt", 32'(bus_a.Stall_Cnt), 32'd15);
    chk("sat_flush_cnt", 32'(bus_a.Flush_Cnt), 32'd2);

    // Clear overrides a concurrent stall increment
    bus_a.Cnt_Clr = 1'b1;
    tick();
    chk("clr_stall_cnt", 32'(bus_a.Stall_Cnt), 32'd0);
    chk("clr_flush_cnt", 32'(bus_a.Flush_Cnt), 32'd0);
    bus_a.Cnt_Clr = 1'b0;
    tick();
    chk("post_clr_stall_cnt", 32'(bus_a.Stall_Cnt), 32'd1);

    // Reset during MD_BUSY on instance B (md_cnt=10 after two edges)
    bus_b.MD_Start_E = 1'b1;
    tick();
    bus_b.MD_Start_E = 1'b0;
    tick();
    chk("b_busy_pre_rst", 32'(bus_b.MD_Busy), 32'd1);
    chk("a_stall_pre_rst", 32'(bus_a.Stall_Cnt), 32'd3);
    rst = 1'b0;
    #1;
    chk("b_rst_busy", 32'(bus_b.MD_Busy), 32'd0);
    chk("b_rst_if_clr", 32'(bus_b.IF_Clr), 32'd1);
    chk("b_rst_id_clr", 32'(bus_b.ID_Clr), 32'd1);
    chk("a_rst_stall_cnt", 32'(bus_a.Stall_Cnt), 32'd0);
    chk("a_rst_pc_en", 32'(bus_a.PC_En), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_a();
    tick();
    bus_b.MD_Use_D = 1'b1;
    #1;
    chk("b_post_rst_busy", 32'(bus_b.MD_Busy), 32'd0);
    chk("b_post_rst_pc_en", 32'(bus_b.PC_En), 32'd1);
    tick();
    chk("b_post_rst_stall_cnt", 32'(bus_b.Stall_Cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
